// File: rtl/pifo_pkg.sv
// rtl/pifo_pkg.sv - shared entry field widths and slot next-state selector for the PIFO rank sorter
package pifo_pkg;

    localparam int PIFO_QUEUE_INDEX_WIDTH = 6;
    localparam int PIFO_RANK_WIDTH        = 3;
    localparam int PIFO_PACKET_WIDTH      = 7;
    // Entries are packed {length, rank, queue}, queue in the low bits.
    localparam int ENTRY_WIDTH = PIFO_QUEUE_INDEX_WIDTH + PIFO_RANK_WIDTH + PIFO_PACKET_WIDTH;

    typedef enum logic [1:0] {
        SLOT_HOLD,
        SLOT_LEFT,
        SLOT_RIGHT,
        SLOT_LOAD
    } slot_sel_e;

endpackage

// File: rtl/pifo_slot.sv
// rtl/pifo_slot.sv - one sorter slot: register, rank compare and hold/shift/load mux
module pifo_slot
    import pifo_pkg::*;
#(
    parameter int QUEUE_INDEX_WIDTH = PIFO_QUEUE_INDEX_WIDTH,
    parameter int RANK_WIDTH        = PIFO_RANK_WIDTH,
    parameter int PACKET_WIDTH      = PIFO_PACKET_WIDTH,
    parameter bit HEAD              = 1'b0
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              push,
    input  logic                                              pop,
    input  logic [QUEUE_INDEX_WIDTH+RANK_WIDTH+PACKET_WIDTH-1:0] new_entry,
    input  logic                                              left_flag,
    input  logic                                              left_valid,
    input  logic [QUEUE_INDEX_WIDTH+RANK_WIDTH+PACKET_WIDTH-1:0] left_entry,
    input  logic                                              right_flag,
    input  logic                                              right_valid,
    input  logic [QUEUE_INDEX_WIDTH+RANK_WIDTH+PACKET_WIDTH-1:0] right_entry,
    output logic                                              insert_flag,
    output logic                                              valid,
    output logic [QUEUE_INDEX_WIDTH+RANK_WIDTH+PACKET_WIDTH-1:0] entry
);

    logic [RANK_WIDTH-1:0] new_rank;
    logic [RANK_WIDTH-1:0] stored_rank;
    slot_sel_e             sel;

    assign new_rank    = new_entry[QUEUE_INDEX_WIDTH +: RANK_WIDTH];
    assign stored_rank = entry[QUEUE_INDEX_WIDTH +: RANK_WIDTH];

    // Set when the new entry belongs at or before this slot; monotone across the array.
    assign insert_flag = !valid || (new_rank < stored_rank);

    // Push+pop is evaluated as if the array had already shifted down by one.
    always_comb begin
        sel = SLOT_HOLD;
        case ({push, pop})
            2'b10:   sel = insert_flag ? (left_flag ? SLOT_LEFT : SLOT_LOAD) : SLOT_HOLD;
            2'b01:   sel = SLOT_RIGHT;
            2'b11:   sel = right_flag ? ((insert_flag && !HEAD) ? SLOT_HOLD : SLOT_LOAD)
                                      : SLOT_RIGHT;
            default: sel = SLOT_HOLD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            entry <= '0;
        end else begin
            case (sel)
                SLOT_LEFT: begin
                    valid <= left_valid;
                    entry <= left_entry;
                end
                SLOT_RIGHT: begin
                    valid <= right_valid;
                    entry <= right_entry;
                end
                SLOT_LOAD: begin
                    valid <= 1'b1;
                    entry <= new_entry;
                end
                default: begin
                    valid <= valid;
                    entry <= entry;
                end
            endcase
        end
    end

endmodule

// File: rtl/pifo_rank_sorter.sv
// rtl/pifo_rank_sorter.sv - rank-sorted PIFO with per-queue pop toggles; optional stats via PIFO_RANK_SORTER_STATS_EN
module pifo_rank_sorter
    import pifo_pkg::*;
#(
    parameter int DEPTH             = 16,
    parameter int QUEUE_COUNT       = 64,
    parameter int QUEUE_INDEX_WIDTH = PIFO_QUEUE_INDEX_WIDTH,
    parameter int RANK_WIDTH        = PIFO_RANK_WIDTH,
    parameter int PACKET_WIDTH      = PIFO_PACKET_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [QUEUE_INDEX_WIDTH-1:0] s_axis_doorbell_queue,
    input  logic [RANK_WIDTH-1:0]        s_axis_doorbell_priority,
    input  logic [PACKET_WIDTH-1:0]      s_axis_doorbell_pkt_length,
    input  logic                         s_axis_doorbell_valid,
    output logic                         s_axis_doorbell_ready,
    output logic [QUEUE_INDEX_WIDTH-1:0] m_axis_sched_queue,
    output logic [RANK_WIDTH-1:0]        m_axis_sched_priority,
    output logic [PACKET_WIDTH-1:0]      m_axis_sched_pkt_length,
    output logic                         m_axis_sched_valid,
    input  logic                         m_axis_sched_ready,
    output logic [QUEUE_COUNT-1:0]       pifo_pop_signal,
`ifdef PIFO_RANK_SORTER_STATS_EN
    output logic [31:0]                  stat_push_count,
    output logic [31:0]                  stat_pop_count,
    output logic [$clog2(DEPTH):0]       stat_max_occupancy,
`endif
    output logic [$clog2(DEPTH):0]       occupancy
);

    localparam int EW = QUEUE_INDEX_WIDTH + RANK_WIDTH + PACKET_WIDTH;
    localparam int OW = $clog2(DEPTH) + 1;

    logic [EW-1:0]    slot_entry [DEPTH];
    logic [DEPTH-1:0] slot_valid;
    logic [DEPTH-1:0] slot_flag;
    logic [EW-1:0]    new_entry;
    logic             push_fire;
    logic             pop_fire;
    logic [OW-1:0]    occupancy_next;

    assign new_entry = {s_axis_doorbell_pkt_length, s_axis_doorbell_priority, s_axis_doorbell_queue};

    assign s_axis_doorbell_ready = !rst && (occupancy < OW'(DEPTH));
    assign m_axis_sched_valid    = (occupancy != '0);
    assign push_fire             = s_axis_doorbell_valid && s_axis_doorbell_ready;
    assign pop_fire              = m_axis_sched_valid && m_axis_sched_ready;

    assign m_axis_sched_queue      = slot_entry[0][QUEUE_INDEX_WIDTH-1:0];
    assign m_axis_sched_priority   = slot_entry[0][QUEUE_INDEX_WIDTH +: RANK_WIDTH];
    assign m_axis_sched_pkt_length = slot_entry[0][EW-1 -: PACKET_WIDTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic          l_flag;
        logic          l_valid;
        logic [EW-1:0] l_entry;
        logic          r_flag;
        logic          r_valid;
        logic [EW-1:0] r_entry;

        if (i == 0) begin : g_left_edge
            assign l_flag  = 1'b0;
            assign l_valid = 1'b0;
            assign l_entry = '0;
        end else begin : g_left
            assign l_flag  = slot_flag[i-1];
            assign l_valid = slot_valid[i-1];
            assign l_entry = slot_entry[i-1];
        end

        // Beyond the last slot everything reads as an empty slot.
        if (i == DEPTH - 1) begin : g_right_edge
            assign r_flag  = 1'b1;
            assign r_valid = 1'b0;
            assign r_entry = '0;
        end else begin : g_right
            assign r_flag  = slot_flag[i+1];
            assign r_valid = slot_valid[i+1];
            assign r_entry = slot_entry[i+1];
        end

        pifo_slot #(
            .QUEUE_INDEX_WIDTH (QUEUE_INDEX_WIDTH),
            .RANK_WIDTH        (RANK_WIDTH),
            .PACKET_WIDTH      (PACKET_WIDTH),
            .HEAD              (i == 0)
        ) u_slot (
            .clk         (clk),
            .rst         (rst),
            .push        (push_fire),
            .pop         (pop_fire),
            .new_entry   (new_entry),
            .left_flag   (l_flag),
            .left_valid  (l_valid),
            .left_entry  (l_entry),
            .right_flag  (r_flag),
            .right_valid (r_valid),
            .right_entry (r_entry),
            .insert_flag (slot_flag[i]),
            .valid       (slot_valid[i]),
            .entry       (slot_entry[i])
        );
    end

    always_comb begin
        occupancy_next = occupancy;
        case ({push_fire, pop_fire})
            2'b10:   occupancy_next = occupancy + OW'(1);
            2'b01:   occupancy_next = occupancy - OW'(1);
            default: occupancy_next = occupancy;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occupancy       <= '0;
            pifo_pop_signal <= '0;
        end else begin
            occupancy <= occupancy_next;
            if (pop_fire) begin
                pifo_pop_signal[m_axis_sched_queue] <= ~pifo_pop_signal[m_axis_sched_queue];
            end
        end
    end

`ifdef PIFO_RANK_SORTER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_push_count    <= '0;
            stat_pop_count     <= '0;
            stat_max_occupancy <= '0;
        end else begin
            if (push_fire) stat_push_count <= stat_push_count + 32'd1;
            if (pop_fire)  stat_pop_count  <= stat_pop_count + 32'd1;
            if (occupancy_next > stat_max_occupancy) stat_max_occupancy <= occupancy_next;
        end
    end
`endif

endmodule

// File: tb/tb_pifo_rank_sorter.sv
// tb/tb_pifo_rank_sorter.sv - scoreboard bench for pifo_rank_sorter against a queue-based reference
module tb_pifo_rank_sorter;

    localparam int DEPTH = 16;
    localparam int QC    = 64;
    localparam int QW    = 6;
    localparam int RW    = 3;
    localparam int PW    = 7;
    localparam int OW    = 5;

    typedef struct {
        int q;
        int r;
        int l;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [QW-1:0] s_q = '0;
    logic [RW-1:0] s_r = '0;
    logic [PW-1:0] s_l = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [QW-1:0] m_q;
    logic [RW-1:0] m_r;
    logic [PW-1:0] m_l;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [QC-1:0] pop_sig;
    logic [OW-1:0] occ;
`ifdef PIFO_RANK_SORTER_STATS_EN
    logic [31:0]   st_push;
    logic [31:0]   st_pop;
    logic [OW-1:0] st_max;
`endif

    pifo_rank_sorter #(
        .DEPTH(DEPTH), .QUEUE_COUNT(QC), .QUEUE_INDEX_WIDTH(QW), .RANK_WIDTH(RW), .PACKET_WIDTH(PW)
    ) dut (
        .clk                        (clk),
        .rst                        (rst),
        .s_axis_doorbell_queue      (s_q),
        .s_axis_doorbell_priority   (s_r),
        .s_axis_doorbell_pkt_length (s_l),
        .s_axis_doorbell_valid      (s_valid),
        .s_axis_doorbell_ready      (s_ready),
        .m_axis_sched_queue         (m_q),
        .m_axis_sched_priority      (m_r),
        .m_axis_sched_pkt_length    (m_l),
        .m_axis_sched_valid         (m_valid),
        .m_axis_sched_ready         (m_ready),
        .pifo_pop_signal            (pop_sig),
`ifdef PIFO_RANK_SORTER_STATS_EN
        .stat_push_count            (st_push),
        .stat_pop_count             (st_pop),
        .stat_max_occupancy         (st_max),
`endif
        .occupancy                  (occ)
    );

    always #5 clk = ~clk;

    ent_t          mdl[$];
    ent_t          exp_q[$];
    int            pop_log[$];
    logic [QC-1:0] mpop = '0;
    int            m_push_cnt = 0;
    int            m_pop_cnt = 0;
    int            m_max = 0;
    int            total = 0;
    int            bad = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endfunction

    // Drive one cycle of stimulus; the reference is advanced after the edge.
    task automatic step(input bit v, input int q, input int r, input int l, input bit rdy);
        bit   pf;
        bit   uf;
        ent_t e;
        int   pos;
        pf = rdy && (mdl.size() > 0);
        uf = v && (mdl.size() < DEPTH);
        s_valid = v;
        s_q = q[QW-1:0];
        s_r = r[RW-1:0];
        s_l = l[PW-1:0];
        m_ready = rdy;
        if (pf) exp_q.push_back(mdl[0]);
        @(posedge clk);
        #1;
        if (pf) begin
            e = mdl.pop_front();
            mpop[e.q] = ~mpop[e.q];
            m_pop_cnt++;
        end
        if (uf) begin
            e.q = q; e.r = r; e.l = l;
            pos = 0;
            while (pos < mdl.size() && mdl[pos].r <= r) pos++;
            mdl.insert(pos, e);
            m_push_cnt++;
        end
        if (mdl.size() > m_max) m_max = mdl.size();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mdl.delete();
        exp_q.delete();
        mpop = '0;
        m_push_cnt = 0;
        m_pop_cnt = 0;
        m_max = 0;
    endtask

    task automatic rand_push(input bit rdy);
        step(1, int'($urandom_range(0, QC-1)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 127)), rdy);
    endtask

    // Monitor: compares handshakes and state against the reference away from the active edge.
    always @(negedge clk) begin
        ent_t e;
        if (rst) begin
            check("ready_in_reset", s_ready, 0);
        end else begin
            check("occupancy", occ, mdl.size());
            check("s_ready", s_ready, mdl.size() < DEPTH);
            check("m_valid", m_valid, mdl.size() > 0);
            check("pop_vector", pop_sig, mpop);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pop", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("head_queue", m_q, e.q);
                    check("head_rank", m_r, e.r);
                    check("head_length", m_l, e.l);
                    pop_log.push_back(int'(m_q));
                end
            end
        end
    end

    initial begin
        int rr[4];
        int qq[4];
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_occ", occ, 0);
        check("reset_valid", m_valid, 0);
        check("reset_head_q", m_q, 0);
        check("reset_pop_vec", pop_sig, 0);

        // Stable rank ordering with ties
        rr = '{5, 2, 7, 2};
        qq = '{1, 2, 3, 4};
        for (int i = 0; i < 4; i++) step(1, qq[i], rr[i], 10 + i, 0);
        pop_log.delete();
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
        idle();
        check("order_len", pop_log.size(), 4);
        if (pop_log.size() == 4) begin
            check("order_0", pop_log[0], 2);
            check("order_1", pop_log[1], 4);
            check("order_2", pop_log[2], 1);
            check("order_3", pop_log[3], 3);
        end
        for (int i = 1; i <= 4; i++) check("drain_toggle", pop_sig[i], 1);

        // Full condition and ready recovery
        do_reset();
        for (int i = 0; i < DEPTH; i++) rand_push(0);
        check("full_occ", occ, DEPTH);
        check("full_ready", s_ready, 0);
        step(1, 33, 0, 1, 0);
        check("full_reject", occ, DEPTH);
        step(0, 0, 0, 0, 1);
        check("ready_after_pop", s_ready, 1);

        // Simultaneous push and pop
        do_reset();
        step(1, 10, 1, 5, 0);
        step(1, 11, 3, 6, 0);
        step(1, 12, 6, 7, 0);
        pop_log.delete();
        step(1, 9, 4, 8, 1);
        check("pushpop_occ", occ, 3);
        check("pushpop_head_rank", m_r, 3);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
        idle();
        check("pushpop_len", pop_log.size(), 4);
        if (pop_log.size() == 4) begin
            check("pushpop_0", pop_log[0], 10);
            check("pushpop_1", pop_log[1], 11);
            check("pushpop_2", pop_log[2], 9);
            check("pushpop_3", pop_log[3], 12);
        end

        // Back-to-back pops of the same queue
        do_reset();
        step(1, 5, 2, 1, 0);
        step(1, 5, 3, 2, 0);
        step(0, 0, 0, 0, 1);
        check("q5_toggle_1", pop_sig[5], 1);
        step(0, 0, 0, 0, 1);
        check("q5_toggle_2", pop_sig[5], 0);

        // Reset mid-stream
        do_reset();
        for (int i = 0; i < 8; i++) rand_push(0);
        step(0, 0, 0, 0, 1);
        do_reset();
        check("midrst_occ", occ, 0);
        check("midrst_valid", m_valid, 0);
        check("midrst_pop_vec", pop_sig, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
        check("midrst_no_toggle", pop_sig, 0);

`ifdef PIFO_RANK_SORTER_STATS_EN
        do_reset();
        for (int i = 0; i < 10; i++) rand_push(0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
        check("stat_push", st_push, 10);
        check("stat_pop", st_pop, 6);
        check("stat_max", st_max, 10);
`endif

        // Randomised traffic with varying fill pressure
        do_reset();
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 500; i++) begin
                bit v;
                bit rdy;
                v   = ($urandom_range(0, 99) < (70 - 20 * p));
                rdy = ($urandom_range(0, 99) < (30 + 20 * p));
                step(v, int'($urandom_range(0, QC-1)), int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 127)), rdy);
            end
        end
        while (mdl.size() > 0) step(0, 0, 0, 0, 1);
        idle();
`ifdef PIFO_RANK_SORTER_STATS_EN
        check("rand_stat_push", st_push, m_push_cnt);
        check("rand_stat_pop", st_pop, m_pop_cnt);
        check("rand_stat_max", st_max, m_max);
`endif
        check("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
